fb_load_scheduler: RTL
======================

Name: fb_load_scheduler

Overview:
Sequences all framebuffer writes for image display. Accepts load/clear requests from the UI logic and starts the SD block reader for a chosen image index. Forwards the reader's pixel write stream to the framebuffer write port, or runs an internal zero-fill engine. Sits between the button/UI FSM, the SD reader and the framebuffer RAM, and is the sole owner of the framebuffer write port.

Parameters:
ADDR_W, 17, framebuffer address width
DATA_W, 16, pixel width (RGB565)
FB_DEPTH, 76800, pixels per image (300 blocks x 256 pixels)
IDX_W, 2, image index width
TIMEOUT_CYCLES, 2000000, loader watchdog limit; counts cycles without an ld_we or ld_done

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request strobe
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  1  0 = load, 1 = clear
req_index  in  IDX_W  image to load (ignored for clear)
ld_start  out  1  one-cycle pulse; starts the SD reader
ld_index  out  IDX_W  image index for the reader; held stable from ld_start until return to IDLE
ld_abort  out  1  one-cycle pulse; forces the reader to stop
ld_we  in  1  reader pixel write strobe
ld_addr  in  ADDR_W  reader pixel address
ld_data  in  DATA_W  reader pixel data
ld_done  in  1  one-cycle pulse; reader finished the image
fb_we  out  1  framebuffer write enable
fb_addr  out  ADDR_W  framebuffer address
fb_data  out  DATA_W  framebuffer data
busy  out  1  high when state != IDLE or the pending slot is full
cur_index  out  IDX_W  index of the last completed load
loaded_valid  out  1  framebuffer holds image cur_index
timeout_err  out  1  sticky loader-timeout flag

Behaviour:
- Reset (reset=0 at a clk edge) sets:
  - state IDLE, pending slot empty
  - fb_we/fb_addr/fb_data = 0
  - ld_start/ld_abort/ld_index = 0
  - cur_index = 0, loaded_valid = 0, timeout_err = 0
  - req_ready = 1, busy = 0
- Reset mid-load produces no ld_abort. The reader shares the same reset.
- Request intake:
  - One-deep pending slot. req_ready = !pend_valid (combinational).
  - Acceptance latches {op, index} into the slot and clears timeout_err.
  - Accept and dispatch in the same cycle are allowed: the slot frees and refills.
- FSM states: IDLE, SKIP, LD_START, LD_WAIT, CLEAR.
- IDLE:
  - Slot empty: stay in IDLE.
  - Slot holds a clear: go to CLEAR with clear counter = 0.
  - Slot holds a load with loaded_valid=1 and index == cur_index: go to SKIP (no SD traffic).
  - Slot holds any other load: go to LD_START and set ld_index.
  - The slot empties on dispatch.
- SKIP: one cycle, then IDLE. Outputs unchanged.
- LD_START:
  - ld_start = 1 for exactly one cycle.
  - loaded_valid <= 0.
  - Watchdog = 0.
  - Next state LD_WAIT.
- LD_WAIT:
  - Each ld_we cycle registers {ld_addr, ld_data} to fb_addr/fb_data with fb_we = 1, one cycle later (fixed 1-cycle latency).
  - Writes with ld_addr >= FB_DEPTH are dropped (fb_we stays 0).
  - The watchdog resets on ld_we or ld_done and otherwise increments.
  - ld_done: cur_index <= ld_index, loaded_valid <= 1, go to IDLE. An ld_we in the same cycle as ld_done is still forwarded.
  - Watchdog reaching TIMEOUT_CYCLES: ld_abort pulse (1 cycle), timeout_err <= 1, loaded_valid stays 0, go to IDLE.
- CLEAR:
  - Each cycle: fb_we = 1, fb_addr = counter, fb_data = 0.
  - The counter increments 0 .. FB_DEPTH-1; a full clear takes exactly FB_DEPTH write cycles.
  - After the write at FB_DEPTH-1: loaded_valid <= 0, go to IDLE. No wrap, no extra write.
- ld_we and ld_done outside LD_WAIT are ignored: no fb write, no state change.
- fb_we is never asserted outside LD_WAIT or CLEAR, apart from the registered last write leaving LD_WAIT.

Optional Feature:
Macro PREEMPT_CLEAR_EN.
- Defined: a clear request accepted while in LD_WAIT or LD_START aborts the load.
  - ld_abort is pulsed the next cycle, with no pending slot used.
  - The FSM goes directly to CLEAR with counter 0; loaded_valid = 0.
  - Any in-flight forwarded write completes first.
- Undefined: a clear arriving during a load waits in the pending slot like any other request and runs after ld_done or timeout.

Test Plan:
Bench parameters: FB_DEPTH=16, TIMEOUT_CYCLES=8.
1. Reset: hold reset=0 for 3 cycles with req_valid=1 -> all outputs 0, req_ready=1, no acceptance; release -> request accepted on the first edge after release.
2. Load index 2: reader emits ld_we at addr 0..15 with data 16'hA500+addr, then ld_done -> ld_start single pulse, ld_index=2, fb writes mirror each input 1 cycle later, cur_index=2, loaded_valid=1.
3. Repeat load index 2 -> SKIP: no ld_start, no fb_we, busy returns to 0 after 2 cycles; then load index 1 -> ld_start fires.
4. Clear request -> exactly 16 consecutive fb_we cycles, addr 0..15, data 0; loaded_valid=0 afterwards; ld_we pulsed during CLEAR produces no write.
5. Load with the reader silent for 8 cycles -> ld_abort pulse, timeout_err=1, loaded_valid=0; next accepted request clears timeout_err. An ld_we at addr 16 in a normal load -> dropped.
6. Clear issued mid-load after 5 pixels -> with PREEMPT_CLEAR_EN: ld_abort then 16 zero writes; without it: req_ready=0 until the slot frees, clear runs after ld_done, final loaded_valid=0.

Source files
------------

// File: rtl/fb_load_scheduler_if.sv
// Handshake and data bundle between the UI request source, SD block reader and framebuffer write port.
// slave modport: the scheduler side. master modport: the side that drives requests and reader traffic.
// Signals: req_* request channel, ld_* reader control/stream, fb_* framebuffer write port.
interface fb_load_scheduler_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 2
);
   logic              req_valid;
   logic              req_ready;
   logic              req_op;
   logic [IDX_W-1:0]  req_index;
   logic              ld_start;
   logic [IDX_W-1:0]  ld_index;
   logic              ld_abort;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_done;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [DATA_W-1:0] fb_data;

   modport master (
      output req_valid, req_op, req_index, ld_we, ld_addr, ld_data, ld_done,
      input  req_ready, ld_start, ld_index, ld_abort, fb_we, fb_addr, fb_data
   );

   modport slave (
      input  req_valid, req_op, req_index, ld_we, ld_addr, ld_data, ld_done,
      output req_ready, ld_start, ld_index, ld_abort, fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/fb_load_scheduler.sv
// Purpose: sole owner of the framebuffer write port; runs image loads via the SD reader or an internal zero-fill.
// Latency: reader pixel writes reach the framebuffer exactly one cycle later; clear writes one pixel per cycle.
// Backpressure: one-deep request slot, req_ready = slot empty; the reader stream itself is never stalled.
// Ports: clk/reset (sync, active-low); bus (slave modport: req_*, ld_*, fb_*);
//        busy, cur_index, loaded_valid, timeout_err status outputs.
// Optional: define PREEMPT_CLEAR_EN to let a clear request abort an in-progress load.
module fb_load_scheduler #(
   parameter int ADDR_W         = 17,
   parameter int DATA_W         = 16,
   parameter int FB_DEPTH       = 76800,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic              clk,
   input  logic              reset,
   fb_load_scheduler_if.slave bus,
   output logic              busy,
   output logic [IDX_W-1:0]  cur_index,
   output logic              loaded_valid,
   output logic              timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(FB_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SKIP, LD_START, LD_WAIT, CLEAR} state_t;

   state_t            state, state_nxt;
   logic              pend_valid;
   logic              pend_op;
   logic [IDX_W-1:0]  pend_index;
   logic [WD_W-1:0]   wd_cnt;
   logic [ADDR_W-1:0] clr_cnt;
   logic              fwd_we;
   logic [ADDR_W-1:0] fwd_addr;
   logic [DATA_W-1:0] fwd_data;
   logic [IDX_W-1:0]  ld_index_q;
   logic              ld_abort_q;

   logic accept, preempt, dispatch, wd_hit, clr_last, fwd_ok, in_wait;

   assign accept   = bus.req_valid & ~pend_valid;
   assign in_wait  = (state == LD_WAIT);
   assign fwd_ok   = ({1'b0, bus.ld_addr} < DEPTH_EXT);
   assign clr_last = (clr_cnt == LAST_ADDR);
   // Timeout fires when the silent cycle about to end would bring the count to the limit.
   assign wd_hit   = in_wait & ~bus.ld_we & ~bus.ld_done & (wd_cnt == WD_LAST);

`ifdef PREEMPT_CLEAR_EN
   // A clear taken during a load bypasses the slot and jumps straight into CLEAR.
   assign preempt = accept & bus.req_op & ((state == LD_START) | (state == LD_WAIT));
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      dispatch  = 1'b0;
      case (state)
         IDLE: begin
            if (pend_valid) begin
               dispatch = 1'b1;
               if (pend_op)
                  state_nxt = CLEAR;
               else if (loaded_valid && (pend_index == cur_index))
                  state_nxt = SKIP;
               else
                  state_nxt = LD_START;
            end
         end
         SKIP:     state_nxt = IDLE;
         LD_START: state_nxt = LD_WAIT;
         LD_WAIT:  if (bus.ld_done || wd_hit) state_nxt = IDLE;
         // A forwarded write still in flight owns the port; the clear stalls for it.
         CLEAR:    if (!fwd_we && clr_last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (preempt) state_nxt = CLEAR;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         pend_valid   <= 1'b0;
         pend_op      <= 1'b0;
         pend_index   <= '0;
         wd_cnt       <= '0;
         clr_cnt      <= '0;
         fwd_we       <= 1'b0;
         fwd_addr     <= '0;
         fwd_data     <= '0;
         ld_index_q   <= '0;
         ld_abort_q   <= 1'b0;
         cur_index    <= '0;
         loaded_valid <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state <= state_nxt;

         if (dispatch) pend_valid <= 1'b0;
         if (accept && !preempt) begin
            pend_valid <= 1'b1;
            pend_op    <= bus.req_op;
            pend_index <= bus.req_index;
         end
         if (accept) timeout_err <= 1'b0;

         fwd_we <= in_wait & bus.ld_we & fwd_ok;
         if (in_wait && bus.ld_we) begin
            fwd_addr <= bus.ld_addr;
            fwd_data <= bus.ld_data;
         end

         ld_abort_q <= preempt | wd_hit;

         if (state == IDLE && state_nxt == LD_START) ld_index_q <= pend_index;
         if (state != CLEAR && state_nxt == CLEAR) clr_cnt <= '0;

         case (state)
            LD_START: begin
               wd_cnt       <= '0;
               loaded_valid <= 1'b0;
            end
            LD_WAIT: begin
               if (bus.ld_we || bus.ld_done) wd_cnt <= '0;
               else                          wd_cnt <= wd_cnt + 1'b1;
               if (bus.ld_done && !preempt) begin
                  cur_index    <= ld_index_q;
                  loaded_valid <= 1'b1;
               end
               if (wd_hit) timeout_err <= 1'b1;
            end
            CLEAR: begin
               if (!fwd_we) begin
                  if (clr_last) loaded_valid <= 1'b0;
                  else          clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: ;
         endcase

         if (preempt) loaded_valid <= 1'b0;
      end
   end

   assign bus.req_ready = ~pend_valid;
   assign bus.ld_start  = (state == LD_START);
   assign bus.ld_index  = ld_index_q;
   assign bus.ld_abort  = ld_abort_q;
   assign bus.fb_we     = fwd_we | (state == CLEAR);
   assign bus.fb_addr   = (state == CLEAR && !fwd_we) ? clr_cnt : fwd_addr;
   assign bus.fb_data   = (state == CLEAR && !fwd_we) ? '0 : fwd_data;
   assign busy          = (state != IDLE) | pend_valid;
endmodule
